// File: rtl/sap1_pkg.sv
// Definitions shared by the SAP-1 registers (A, B, output and instruction).
package sap1_pkg;

    localparam int unsigned SAP1_WIDTH = 8;

    typedef logic [SAP1_WIDTH-1:0] sap1_word_t;

    // Control-line polarities used by the controller/sequencer.
    localparam logic LOAD_ACTIVE   = 1'b0;
    localparam logic ENABLE_ACTIVE = 1'b1;

    // True when the active-low load strobe is asserted.
    function automatic logic load_asserted(input logic load_line);
        return load_line == LOAD_ACTIVE;
    endfunction

    // True when the active-high output enable is asserted.
    function automatic logic enable_asserted(input logic enable_line);
        return enable_line == ENABLE_ACTIVE;
    endfunction

endpackage

// File: rtl/sap1_tristate_driver.sv
// Tri-state driver onto the shared W bus, shared by every bus-driving register.
module sap1_tristate_driver #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  logic             oe,
    inout  wire  [WIDTH-1:0] bus
);

    // Release every bit when not enabled so other sources can own the bus.
    assign bus = oe ? data : {WIDTH{1'bz}};

endmodule

// File: rtl/sap1_accumulator.sv
// SAP-1 A register: loads from the W bus, feeds the ALU, drives the bus on enable.
module sap1_accumulator
    import sap1_pkg::*;
#(
    parameter int unsigned WIDTH = SAP1_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             enable,
    output logic [WIDTH-1:0] alu_connection,
    inout  wire  [WIDTH-1:0] w_bus
);

    logic [WIDTH-1:0] r_a_q;
    logic             w_load;
    logic             w_drive;

    assign w_load  = load_asserted(load);
    assign w_drive = enable_asserted(enable);

    // Storage flop: async clear, otherwise capture the bus while load is asserted.
    // With load and enable together the bus carries r_a_q, so the value recirculates.
    // Undriven bus bits are captured unfiltered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a_q <= '0;
        end else if (w_load) begin
            r_a_q <= w_bus;
        end
    end

    // The ALU always sees the stored value, including during reset.
    assign alu_connection = r_a_q;

    // Reset does not gate the driver; enabling during reset puts 0 on the bus.
    sap1_tristate_driver #(
        .WIDTH (WIDTH)
    ) u_bus_driver (
        .data (r_a_q),
        .oe   (w_drive),
        .bus  (w_bus)
    );

endmodule

// File: tb/tb_sap1_accumulator.sv
// Directed self-checking bench for sap1_accumulator.
module tb_sap1_accumulator;

    localparam int unsigned W = 8;

    // Bus expectation kinds.
    localparam int BusNone  = 0;
    localparam int BusValue = 1;
    localparam int BusZ     = 2;

    logic         clk;
    logic         reset;
    logic         load;
    logic         enable;
    logic [W-1:0] alu_connection;
    wire  [W-1:0] w_bus;

    logic         tb_drv_en;
    logic [W-1:0] tb_drv;

    int n_checks;
    int n_errors;

    assign w_bus = tb_drv_en ? tb_drv : 8'bzzzz_zzzz;

    sap1_accumulator #(
        .WIDTH (W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .load           (load),
        .enable         (enable),
        .alu_connection (alu_connection),
        .w_bus          (w_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        string        name;
        logic         reset;
        logic         load;
        logic         enable;
        logic         drv_en;
        logic [W-1:0] drv;
        int           clocks;
        logic [W-1:0] exp_alu;
        int           bus_kind;
        logic [W-1:0] exp_bus;
    } vec_t;

    task automatic check8(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_z(input string name, input logic is_z);
        n_checks++;
        if (!is_z) begin
            n_errors++;
            $display("FAIL %s: actual=%h required=zz", name, w_bus);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    vec_t vecs[8];

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b0;
        load      = 1'b1;
        enable    = 1'b0;
        tb_drv_en = 1'b0;
        tb_drv    = '0;

        //          name          rst   ld    en    drv   val    clk alu    bus       busval
        vecs[0] = '{"reset_hold", 1'b0, 1'b0, 1'b0, 1'b1, 8'h0F, 3, 8'h00, BusValue, 8'h0F};
        vecs[1] = '{"load_0f",    1'b1, 1'b0, 1'b0, 1'b1, 8'h0F, 1, 8'h0F, BusValue, 8'h0F};
        vecs[2] = '{"hold_rel",   1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1, 8'h0F, BusZ,     8'h00};
        vecs[3] = '{"enable_on",  1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 0, 8'h0F, BusValue, 8'h0F};
        vecs[4] = '{"enable_off", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 0, 8'h0F, BusZ,     8'h00};
        vecs[5] = '{"hold_a5",    1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 3, 8'h0F, BusValue, 8'hA5};
        vecs[6] = '{"load_3c",    1'b1, 1'b0, 1'b0, 1'b1, 8'h3C, 1, 8'h3C, BusValue, 8'h3C};
        vecs[7] = '{"hold_3c",    1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1, 8'h3C, BusZ,     8'h00};

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            reset     = vecs[i].reset;
            load      = vecs[i].load;
            enable    = vecs[i].enable;
            tb_drv_en = vecs[i].drv_en;
            tb_drv    = vecs[i].drv;
            if (vecs[i].clocks == 0) #1;
            else tick(vecs[i].clocks);
            check8({vecs[i].name, "_alu"}, alu_connection, vecs[i].exp_alu);
            if (vecs[i].bus_kind == BusValue)
                check8({vecs[i].name, "_bus"}, w_bus, vecs[i].exp_bus);
            else if (vecs[i].bus_kind == BusZ)
                check_z({vecs[i].name, "_busz"}, w_bus === 8'bzzzz_zzzz);
        end

        // Load and enable together with no external driver: value recirculates.
        @(negedge clk);
        load   = 1'b0;
        enable = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick(1);
            check8($sformatf("ld_en_alu_%0d", c), alu_connection, 8'h3C);
            check8($sformatf("ld_en_bus_%0d", c), w_bus, 8'h3C);
        end
        @(negedge clk);
        load   = 1'b1;
        enable = 1'b0;

        // Reload 0x0F, then assert reset between edges.
        @(negedge clk);
        tb_drv_en = 1'b1;
        tb_drv    = 8'h0F;
        load      = 1'b0;
        tick(1);
        check8("reload_0f", alu_connection, 8'h0F);
        @(negedge clk);
        load      = 1'b1;
        tb_drv_en = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check8("async_rst_alu", alu_connection, 8'h00);
        enable = 1'b1;
        #1;
        check8("async_rst_bus", w_bus, 8'h00);
        check8("async_rst_pre_edge", {7'd0, clk}, 8'h00);

        // Reset overrides load across edges.
        @(negedge clk);
        enable    = 1'b0;
        tb_drv_en = 1'b1;
        tb_drv    = 8'h77;
        load      = 1'b0;
        tick(2);
        check8("rst_over_load", alu_connection, 8'h00);

        // Release reset mid-cycle with load asserted: next edge captures.
        @(negedge clk);
        tb_drv = 8'h5A;
        reset  = 1'b1;
        #1;
        check8("rst_release_wait", alu_connection, 8'h00);
        tick(1);
        check8("rst_release_cap", alu_connection, 8'h5A);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
